// File: rtl/sqm_cmd_pkg.sv
// Shared constants for the sound command FIFO: parameter bounds and status-word layout.
// Status layout is used when SOUND_CMD_FIFO_STATUS_EN is defined.
package sqm_cmd_pkg;

  localparam int DW_MIN    = 4;
  localparam int DW_MAX    = 16;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 64;

  // The count field sits at the bottom; flag positions are offsets above it,
  // because the count width follows DEPTH.
  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int stat_pos(input int depth, input int flag_offset);
    return STAT_CNT_LSB + cnt_width(depth) + flag_offset;
  endfunction

endpackage

// File: rtl/sound_cmd_mem.sv
// Command storage: DEPTH x DW, one synchronous write port, asynchronous read.
module sound_cmd_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sound_cmd_fifo.sv
// Main-CPU to sound-CPU command FIFO with falling-edge read detection and wired-OR read bus.
// Define SOUND_CMD_FIFO_STATUS_EN to expose the status register at adr=1.
module sound_cmd_fifo
  import sqm_cmd_pkg::*;
#(
  parameter int            DW         = 8,
  parameter int            DEPTH      = 4,
  parameter logic [DW-1:0] RESET_CODE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          cs,
  input  logic          rd_n,
  input  logic          adr,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic          int_n,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic [DW-1:0] last_reg;
  logic [DW-1:0] dout_reg;
  logic          int_n_reg;
  logic          rd_n_q;

  logic          rd_fall;
  logic          data_rd;
  logic          stat_rd;
  logic          pop;
  logic          push;
  logic          drop;
  logic [DW-1:0] head_data;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign ovf   = ovf_reg;
  assign dout  = dout_reg;
  assign int_n = int_n_reg;

  // One pop per access: only the cycle where rd_n goes low counts.
  assign rd_fall = cs & ~rd_n & rd_n_q;

`ifdef SOUND_CMD_FIFO_STATUS_EN
  localparam int STAT_W = CW + 3;

  logic [STAT_W-1:0] stat_word;
  logic [DW-1:0]     status_dw;

  always_comb begin
    stat_word = '0;
    stat_word[STAT_CNT_LSB +: CW]         = count_reg;
    stat_word[stat_pos(DEPTH, STAT_EMPTY)] = empty;
    stat_word[stat_pos(DEPTH, STAT_FULL)]  = full;
    stat_word[stat_pos(DEPTH, STAT_OVF)]   = ovf_reg;
  end

  // Zero-pad (or truncate for very narrow buses) the status word onto DW.
  for (genvar gi = 0; gi < DW; gi++) begin : g_stat
    if (gi < STAT_W) begin : g_bit
      assign status_dw[gi] = stat_word[gi];
    end else begin : g_pad
      assign status_dw[gi] = 1'b0;
    end
  end

  assign data_rd = rd_fall & ~adr;
  assign stat_rd = rd_fall & adr;
`else
  logic unused_adr;
  assign unused_adr = adr;
  assign data_rd    = rd_fall;
  assign stat_rd    = 1'b0;
`endif

  // clr wins over both sides; a full FIFO still accepts a write when it pops.
  assign pop  = data_rd & ~empty & ~clr;
  assign push = wr & (~full | pop) & ~clr;
  assign drop = wr & full & ~pop & ~clr;

  sound_cmd_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_reg),
    .wdata (din),
    .raddr (head_reg),
    .rdata (head_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      last_reg  <= RESET_CODE;
      int_n_reg <= 1'b1;
      rd_n_q    <= 1'b1;
    end else begin
      rd_n_q    <= rd_n;
      int_n_reg <= (count_reg == '0);
      if (clr) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        ovf_reg   <= 1'b0;
      end else begin
        if (push) begin
          tail_reg <= tail_reg + PW'(1);
        end
        if (pop) begin
          head_reg <= head_reg + PW'(1);
        end
        unique case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
        if (drop) begin
          ovf_reg <= 1'b1;
        end else if (stat_rd) begin
          ovf_reg <= 1'b0;
        end
      end
      if (pop) begin
        last_reg <= head_data;
      end
    end
  end

  // Read bus: load on the falling edge, hold during the access, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg <= '0;
    end else if (data_rd) begin
      dout_reg <= pop ? head_data : last_reg;
`ifdef SOUND_CMD_FIFO_STATUS_EN
    end else if (stat_rd) begin
      dout_reg <= status_dw;
`endif
    end else if (!(cs && !rd_n)) begin
      dout_reg <= '0;
    end
  end

endmodule

// File: tb/tb_sound_cmd_fifo.sv
// Randomized self-checking bench for sound_cmd_fifo against a queue-based reference model.
module tb_sound_cmd_fifo;

  localparam int            DW         = 8;
  localparam int            DEPTH      = 4;
  localparam logic [DW-1:0] RESET_CODE = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] din = '0;
  logic          cs = 1'b0;
  logic          rd_n = 1'b1;
  logic          adr = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] dout;
  logic          int_n;
  logic          empty;
  logic          full;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;
  bit            m_ovf;

  sound_cmd_fifo #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .RESET_CODE (RESET_CODE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (din),
    .cs    (cs),
    .rd_n  (rd_n),
    .adr   (adr),
    .clr   (clr),
    .dout  (dout),
    .int_n (int_n),
    .empty (empty),
    .full  (full),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] stat_model();
    int cw;
    logic [15:0] s;
    cw = $clog2(DEPTH) + 1;
    s = 16'(mq.size());
    if (mq.size() == 0) s[cw] = 1'b1;
    if (mq.size() == DEPTH) s[cw+1] = 1'b1;
    if (m_ovf) s[cw+2] = 1'b1;
    return s[DW-1:0];
  endfunction

  task automatic check_flags(input string tag);
    n_checks++;
    if (empty !== (mq.size() == 0)) begin
      n_fail++;
      $display("FAIL %s empty: got %b expected %b", tag, empty, mq.size() == 0);
    end
    n_checks++;
    if (full !== (mq.size() == DEPTH)) begin
      n_fail++;
      $display("FAIL %s full: got %b expected %b", tag, full, mq.size() == DEPTH);
    end
    n_checks++;
    if (ovf !== m_ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %b expected %b", tag, ovf, m_ovf);
    end
    n_checks++;
    if (int_n !== (mq.size() == 0)) begin
      n_fail++;
      $display("FAIL %s int_n: got %b expected %b", tag, int_n, mq.size() == 0);
    end
  endtask

  // One transaction: optional write and optional read access in the same cycle,
  // then the access is released and the bus must return to zero.
  task automatic do_cycle(input bit w, input logic [DW-1:0] v, input bit r, input bit a,
                          input string tag);
    logic [DW-1:0] exp;
    bit popped;
    bit full_pre;
    bit is_stat;
    exp = '0;
    popped = 0;
    is_stat = 0;
`ifdef SOUND_CMD_FIFO_STATUS_EN
    is_stat = a;
`endif
    full_pre = (mq.size() == DEPTH);
    if (r && is_stat) begin
      exp = stat_model();
      m_ovf = 0;
    end else if (r) begin
      if (mq.size() > 0) begin
        exp = mq.pop_front();
        m_last = exp;
        popped = 1;
      end else begin
        exp = m_last;
      end
    end
    if (w) begin
      if (!full_pre || popped) mq.push_back(v);
      else m_ovf = 1;
    end
    wr = w; din = v; cs = r; rd_n = !r; adr = a;
    @(posedge clk); #1;
    wr = 0;
    if (r) begin
      n_checks++;
      if (dout !== exp) begin
        n_fail++;
        $display("FAIL %s dout: got %h expected %h", tag, dout, exp);
      end
    end
    cs = 0; rd_n = 1; adr = 0;
    @(posedge clk); #1;
    if (r) begin
      n_checks++;
      if (dout !== '0) begin
        n_fail++;
        $display("FAIL %s dout_idle: got %h expected 00", tag, dout);
      end
    end
    check_flags(tag);
    $display("%s: wr=%0b din=%h rd=%0b adr=%0b dout_exp=%h level=%0d", tag, w, v, r, a, exp,
             mq.size());
  endtask

  task automatic do_reset();
    wr = 0; cs = 0; rd_n = 1; adr = 0; clr = 0;
    reset = 1;
    mq.delete();
    m_last = RESET_CODE;
    m_ovf = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dout !== '0) begin
      n_fail++;
      $display("FAIL reset dout: got %h expected 00", dout);
    end
    check_flags("reset");
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    do_reset();
    do_cycle(1, 8'h12, 0, 0, "basic_push");
    do_cycle(1, 8'h34, 0, 0, "basic_push");
    do_cycle(1, 8'h56, 0, 0, "basic_push");
    repeat (3) do_cycle(0, 8'h00, 1, 0, "basic_read");
  endtask

  task automatic test_empty_read();
    do_reset();
    do_cycle(0, 8'h00, 1, 0, "empty_reset_code");
    do_cycle(1, 8'h21, 0, 0, "empty_push");
    do_cycle(0, 8'h00, 1, 0, "empty_pop");
    do_cycle(0, 8'h00, 1, 0, "empty_last");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1, 8'(8'h40 + i), 0, 0, "ovf_push");
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 8'h00, 1, 0, "ovf_read");
    do_cycle(0, 8'h00, 1, 0, "ovf_read_empty");
  endtask

  task automatic test_full_wr_pop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 8'(8'h60 + i), 0, 0, "fwp_fill");
    do_cycle(1, 8'h99, 1, 0, "fwp_wr_pop");
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 8'h00, 1, 0, "fwp_drain");
  endtask

  task automatic test_wr_empty_read();
    do_reset();
    do_cycle(1, 8'h3C, 1, 0, "wer_both");
    do_cycle(0, 8'h00, 1, 0, "wer_read");
  endtask

  task automatic test_hold();
    do_reset();
    do_cycle(1, 8'hA1, 0, 0, "hold_push");
    do_cycle(1, 8'hB2, 0, 0, "hold_push");
    cs = 1; rd_n = 0;
    void'(mq.pop_front());
    m_last = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dout !== 8'hA1) begin
        n_fail++;
        $display("FAIL hold dout cycle %0d: got %h expected a1", i, dout);
      end
    end
    cs = 0; rd_n = 1;
    @(posedge clk); #1;
    check_flags("hold_after");
    do_cycle(0, 8'h00, 1, 0, "hold_next");
  endtask

  task automatic test_clr();
    do_reset();
    do_cycle(1, 8'h11, 0, 0, "clr_push");
    do_cycle(0, 8'h00, 1, 0, "clr_pop");
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1, 8'(8'h70 + i), 0, 0, "clr_fill");
    clr = 1; wr = 1; din = 8'hEE;
    @(posedge clk); #1;
    clr = 0; wr = 0;
    mq.delete();
    m_ovf = 0;
    @(posedge clk); #1;
    check_flags("clr_after");
    do_cycle(0, 8'h00, 1, 0, "clr_empty_read");
  endtask

  task automatic test_status();
`ifdef SOUND_CMD_FIFO_STATUS_EN
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1, 8'(8'h80 + i), 0, 0, "stat_fill");
    do_cycle(0, 8'h00, 1, 0, "stat_pop");
    do_cycle(0, 8'h00, 1, 0, "stat_pop");
    do_cycle(0, 8'h00, 1, 1, "stat_read1");
    do_cycle(0, 8'h00, 1, 1, "stat_read2");
    do_cycle(0, 8'h00, 1, 0, "stat_data");
`else
    do_reset();
    do_cycle(1, 8'h5A, 0, 0, "adr_push");
    do_cycle(0, 8'h00, 1, 1, "adr_ignored");
    do_cycle(0, 8'h00, 1, 1, "adr_ignored_empty");
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1, 8'(8'hC0 + i), 0, 0, "rmid_push");
    cs = 1; rd_n = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    mq.delete();
    m_last = RESET_CODE;
    m_ovf = 0;
    n_checks++;
    if (dout !== '0) begin
      n_fail++;
      $display("FAIL rmid dout: got %h expected 00", dout);
    end
    check_flags("rmid_in_reset");
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    wr = 1; din = 8'h77;
    @(posedge clk); #1;
    wr = 0;
    mq.push_back(8'h77);
    repeat (3) @(posedge clk);
    #1;
    check_flags("rmid_no_pop");
    cs = 0; rd_n = 1;
    @(posedge clk); #1;
    do_cycle(0, 8'h00, 1, 0, "rmid_read");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bit w;
      bit r;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      do_cycle(w, 8'($urandom), r, 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_overflow();
    test_full_wr_pop();
    test_wr_empty_read();
    test_hold();
    test_clr();
    test_status();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_cmd_fifo.md
SOUND_CMD_FIFO -- requirements
Module: sound_cmd_fifo

Interface
REQ-001 SHALL have parameter DW, 8, command/data width in bits (4..16).
REQ-002 SHALL have parameter DEPTH, 4, number of FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter RESET_CODE, 0, value dout returns on an empty-read before any command was ever popped.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr  input  1  main-CPU write strobe, one push per clk cycle high.
REQ-007 SHALL have port din  input  DW  command code pushed on wr.
REQ-008 SHALL have port cs  input  1  sound-CPU address decode for this block.
REQ-009 SHALL have port rd_n  input  1  sound-CPU read strobe, active-low.
REQ-010 SHALL have port adr  input  1  register select: 0 = data, 1 = status (status only with macro).
REQ-011 SHALL have port clr  input  1  synchronous flush.
REQ-012 SHALL have port dout  output  DW  read data, zero when not selected (wired-OR bus).
REQ-013 SHALL have port int_n  output  1  active-low request to sound CPU.
REQ-014 SHALL have ports empty, full, ovf  output  1 each  FIFO status flags.

Function
REQ-015 rd_fall SHALL be cs & ~rd_n & rd_n_q, where rd_n_q is rd_n registered one cycle; one pop max per read access.
REQ-016 On rd_fall with adr=0 and not empty: dout <= head entry next edge, head advances, count decrements.
REQ-017 On rd_fall with adr=0 and empty: dout <= last popped value (RESET_CODE if none), no pointer change.
REQ-018 dout SHALL hold its value while cs & ~rd_n stays high and SHALL be 0 on the edge after cs or rd_n deasserts.
REQ-019 Push on wr when not full: entry written at tail, tail advances, count increments; visible to pop the next cycle (no same-cycle bypass).
REQ-020 wr when full with no simultaneous pop: data dropped, ovf set sticky.
REQ-021 wr and pop in same cycle when full: both succeed, count unchanged, ovf not set.
REQ-022 wr and empty-read in same cycle: push succeeds, read returns last popped value.
REQ-023 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-024 empty = (count==0), full = (count==DEPTH), both combinational from registered count.
REQ-025 int_n SHALL be registered and equal ~(count!=0) one cycle after count changes.
REQ-026 clr SHALL zero pointers, count and ovf next edge; clr overrides simultaneous wr and pop; dout last-popped value kept.

Reset
REQ-027 On reset: pointers, count = 0; ovf = 0; dout = 0; int_n = 1; rd_n_q = 1; last-popped = RESET_CODE.
REQ-028 Reset mid-access SHALL not produce a pop on deassertion while rd_n is already low (rd_n_q reset to 1 requires a new rising-then-falling sequence... rd_n_q samples rd_n first cycle after reset, so a low rd_n pops at most once).
REQ-029 FIFO storage contents need not be reset.

Configuration
REQ-030 Macro SOUND_CMD_FIFO_STATUS_EN defined: rd_fall with adr=1 returns status {ovf, full, empty, count} in low bits, zero-padded to DW, no pop; status read clears ovf.
REQ-031 Macro undefined: adr ignored, every read is a data read; ovf cleared only by clr or reset.

Structure
REQ-032 Shared package sqm_cmd_pkg SHALL hold status bit positions (STAT_OVF, STAT_FULL, STAT_EMPTY, STAT_CNT_LSB) and DW/DEPTH bounds.
REQ-033 Storage SHALL be sub-module sound_cmd_mem (DEPTH x DW, one write port, async read).

Verification
REQ-034 DW=8, DEPTH=4: push 0x12,0x34,0x56; three reads -> dout 0x12,0x34,0x56; int_n high after third pop.
REQ-035 Push 5 values into DEPTH=4 -> full=1, ovf=1, fifth dropped; reads return first four only.
REQ-036 Full FIFO, wr 0x99 on same cycle as pop -> count stays 4, ovf=0, 0x99 read last.
REQ-037 Read from empty after reset -> dout = RESET_CODE; after popping 0x21 and empty read -> dout 0x21.
REQ-038 With SOUND_CMD_FIFO_STATUS_EN, 2 entries plus overflow, adr=1 read -> status ovf=1, count=2, no pop; second status read ovf=0.
REQ-039 Assert reset with 3 entries while rd_n low -> count=0, int_n=1, dout=0, no pop after release until next rd_n falling edge.
